// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared types, defaults and helpers for the FSM event monitor
//
// Purpose : readout FSM state type, default channel count and counter width,
//           and the channel-index width helper used by the top and interface.
// Ports   : none (package)
package fsm_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_CNT_W = 8;

   // A single channel still needs a 1-bit index port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsm_event_monitor_if.sv
// rtl/fsm_event_monitor_if.sv - valid/ready readout stream of the FSM event monitor
//
// Purpose : groups the snapshot readout beat signals.
// Signals : out_valid, out_ready, out_ch, out_cnt, out_ovf, out_last
// Modports: master (monitor drives beats), slave (consumer drives out_ready)
interface fsm_event_monitor_if #(
   parameter int N_CH  = fsm_mon_pkg::DEF_N_CH,
   parameter int CNT_W = fsm_mon_pkg::DEF_CNT_W
);
   localparam int CH_W = fsm_mon_pkg::ch_w(N_CH);

   logic             out_valid;
   logic             out_ready;
   logic [CH_W-1:0]  out_ch;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;
   logic             out_last;

   modport master (
      output out_valid, out_ch, out_cnt, out_ovf, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_ch, out_cnt, out_ovf, out_last,
      output out_ready
   );
endinterface

// File: rtl/fsm_mon_edge_cnt.sv
// rtl/fsm_mon_edge_cnt.sv - per-channel rising-edge detector with saturating counter
//
// Purpose : counts rising edges of one event line; saturates at all-ones and
//           raises a sticky overflow flag on any edge seen while saturated.
// Ports   : clk, rst (sync, active-high), ev (event level), clear (zero cnt/ovf),
//           snap (readout snapshot cycle), cnt_o, ovf_o
// Config  : FSM_MON_CLEAR_ON_READ_EN - snap also zeroes cnt/ovf before the
//           same-cycle edge is applied.
module fsm_mon_edge_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ev,
   input  logic             clear,
   input  logic             snap,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rise;

   assign rise = ev & ~prev_q;

`ifndef FSM_MON_CLEAR_ON_READ_EN
   logic unused_snap;
   assign unused_snap = snap;
`endif

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
`ifdef FSM_MON_CLEAR_ON_READ_EN
      // The shadow copies cnt_q this cycle, so restart from zero and let a
      // snap-cycle edge land in the fresh count.
      if (snap) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end
`endif
      if (clear) begin
         // clear wins: a same-cycle edge is deliberately dropped
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (rise) begin
         if (&cnt_d) ovf_d = 1'b1;
         else        cnt_d = cnt_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= ev;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/fsm_event_monitor.sv
// rtl/fsm_event_monitor.sv - edge counters for FSM outputs with snapshot readout stream
//
// Purpose : counts rising edges on N_CH event lines; on rd_req snapshots all
//           counters and streams them one channel per valid/ready beat.
// Ports   : clk, rst (sync, active-high), ev_in[N_CH], clear, rd_req, busy,
//           out_if (master: out_valid/out_ready/out_ch/out_cnt/out_ovf/out_last)
// Config  : FSM_MON_CLEAR_ON_READ_EN - counters restart from zero after each snapshot.
module fsm_event_monitor
   import fsm_mon_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      ev_in,
   input  logic                 clear,
   input  logic                 rd_req,
   output logic                 busy,
   fsm_event_monitor_if.master  out_if
);

   localparam int              CH_W     = ch_w(N_CH);
   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);

   logic [CNT_W-1:0] cnt_w   [N_CH];
   logic             ovf_w   [N_CH];
   logic [CNT_W-1:0] sh_cnt_q[N_CH];
   logic             sh_ovf_q[N_CH];

   state_t           state_q, state_d;
   logic [CH_W-1:0]  idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [CNT_W-1:0] ocnt_q, ocnt_d;
   logic             oovf_q, oovf_d;
   logic             last_q, last_d;
   logic             snap;

   assign snap = (state_q == ST_SNAP);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      fsm_mon_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .ev    (ev_in[g]),
         .clear (clear),
         .snap  (snap),
         .cnt_o (cnt_w[g]),
         .ovf_o (ovf_w[g])
      );
   end

   // Shadow holds the counters as they were on entering SNAP; later edges
   // and clears only touch the live counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            sh_cnt_q[i] <= '0;
            sh_ovf_q[i] <= 1'b0;
         end
      end else if (snap) begin
         for (int i = 0; i < N_CH; i++) begin
            sh_cnt_q[i] <= cnt_w[i];
            sh_ovf_q[i] <= ovf_w[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      ch_d    = ch_q;
      ocnt_d  = ocnt_q;
      oovf_d  = oovf_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) state_d = ST_SNAP;
         end
         ST_SNAP: begin
            // Beat 0 comes straight from the live counters, which equal what
            // the shadow is capturing this cycle.
            state_d = ST_SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            ch_d    = '0;
            ocnt_d  = cnt_w[0];
            oovf_d  = ovf_w[0];
            last_d  = (N_CH == 1);
         end
         ST_SEND: begin
            if (out_if.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = idx_q + CH_W'(1);
                  ch_d   = idx_d;
                  ocnt_d = sh_cnt_q[idx_d];
                  oovf_d = sh_ovf_q[idx_d];
                  last_d = (idx_d == LAST_IDX);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         ocnt_q  <= '0;
         oovf_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ch_q    <= ch_d;
         ocnt_q  <= ocnt_d;
         oovf_q  <= oovf_d;
         last_q  <= last_d;
      end
   end

   assign busy             = (state_q != ST_IDLE);
   assign out_if.out_valid = valid_q;
   assign out_if.out_ch    = ch_q;
   assign out_if.out_cnt   = ocnt_q;
   assign out_if.out_ovf   = oovf_q;
   assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_fsm_event_monitor.sv
// tb/tb_fsm_event_monitor.sv - self-checking bench for fsm_event_monitor
module tb_fsm_event_monitor;

   localparam int N  = 4;
   localparam int CW = 4;
   localparam int MAXC = (1 << CW) - 1;
`ifdef FSM_MON_CLEAR_ON_READ_EN
   localparam bit COR = 1'b1;
`else
   localparam bit COR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] ev_in;
   logic         clear;
   logic         rd_req;
   logic         busy;

   fsm_event_monitor_if #(.N_CH(N), .CNT_W(CW)) mon_if ();

   fsm_event_monitor #(.N_CH(N), .CNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .ev_in  (ev_in),
      .clear  (clear),
      .rd_req (rd_req),
      .busy   (busy),
      .out_if (mon_if.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: per-channel edge counts, sticky flags, last seen level
   int           m_cnt[N];
   bit           m_ovf[N];
   logic [N-1:0] m_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         m_ovf[i] = 0;
      end
      m_prev = '0;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, settle.
   task automatic tick(input logic [N-1:0] e, input logic clr, input logic rq, input bit snap);
      ev_in  = e;
      clear  = clr;
      rd_req = rq;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         for (int i = 0; i < N; i++) begin
            bit r;
            r = e[i] && !m_prev[i];
            if (clr) begin
               m_cnt[i] = 0;
               m_ovf[i] = 0;
            end else begin
               if (snap && COR) begin
                  m_cnt[i] = 0;
                  m_ovf[i] = 0;
               end
               if (r) begin
                  if (m_cnt[i] == MAXC) m_ovf[i] = 1;
                  else m_cnt[i]++;
               end
            end
         end
         m_prev = e;
      end
      #1;
   endtask

   task automatic pulse(input int ch);
      logic [N-1:0] e;
      e = '0;
      e[ch] = 1'b1;
      tick(e, 1'b0, 1'b0, 1'b0);
      tick('0, 1'b0, 1'b0, 1'b0);
   endtask

   int last_ch0;

   // Full readout: rd_req, SNAP, then N beats with an optional stall on one channel.
   task automatic readout(input int stall_ch, input int stall_len, input bit noise,
                          input bit clr_at_snap, input logic [N-1:0] snap_ev);
      int  exp_c[N];
      bit  exp_o[N];
      logic [N-1:0] e;
      bit  rdy;
      int  beats;
      mon_if.out_ready = 1'b1;
      e = noise ? N'($urandom) : '0;
      tick(e, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
         exp_c[i] = m_cnt[i];
         exp_o[i] = m_ovf[i];
      end
      chk("valid_at_t1", mon_if.out_valid, 0);
      chk("busy_snap", busy, 1);
      tick(snap_ev, clr_at_snap, 1'b0, 1'b1);
      chk("valid_at_t2", mon_if.out_valid, 1);
      beats = 0;
      for (int b = 0; b < N; b++) begin
         for (int w = 0; w < 40; w++) begin
            chk($sformatf("beat%0d_valid", b), mon_if.out_valid, 1);
            chk($sformatf("beat%0d_ch", b), mon_if.out_ch, b);
            chk($sformatf("beat%0d_cnt", b), mon_if.out_cnt, exp_c[b]);
            chk($sformatf("beat%0d_ovf", b), mon_if.out_ovf, exp_o[b]);
            chk($sformatf("beat%0d_last", b), mon_if.out_last, (b == N - 1));
            chk($sformatf("beat%0d_busy", b), busy, 1);
            rdy = !(b == stall_ch && w < stall_len);
            mon_if.out_ready = rdy;
            e = noise ? N'($urandom) : '0;
            tick(e, 1'b0, (w == 1), 1'b0);
            if (rdy) begin
               beats++;
               break;
            end
         end
      end
      chk("beat_count", beats, N);
      chk("valid_after_last", mon_if.out_valid, 0);
      chk("busy_after_last", busy, 0);
      last_ch0 = exp_c[0];
   endtask

   initial begin
      rst = 1'b1;
      ev_in = '0;
      clear = 1'b0;
      rd_req = 1'b0;
      mon_if.out_ready = 1'b0;
      model_reset();

      // 1: reset then simple counts
      for (int i = 0; i < 3; i++) tick('0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_valid", mon_if.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ch", mon_if.out_ch, 0);
      chk("rst_cnt", mon_if.out_cnt, 0);
      chk("rst_ovf", mon_if.out_ovf, 0);
      chk("rst_last", mon_if.out_last, 0);
      for (int i = 0; i < 3; i++) pulse(0);
      pulse(2);
      readout(-1, 0, 1'b0, 1'b0, '0);
      if (!COR) chk("t1_ch0_cnt", last_ch0, 3);

      // 2: level held high counts once
      for (int i = 0; i < 20; i++) tick(4'b0010, 1'b0, 1'b0, 1'b0);
      tick('0, 1'b0, 1'b0, 1'b0);
      readout(-1, 0, 1'b0, 1'b0, '0);

      // 3: saturation on ch3, then clear
      for (int i = 0; i < 17; i++) pulse(3);
      readout(-1, 0, 1'b0, 1'b0, '0);
      tick('0, 1'b1, 1'b0, 1'b0);
      readout(-1, 0, 1'b0, 1'b0, '0);

      // 4: stall on ch1 with spurious rd_req
      pulse(1);
      pulse(0);
      readout(1, 5, 1'b0, 1'b0, '0);

      // 5: clear and rise on ch0 in the same cycle
      tick(4'b0001, 1'b1, 1'b0, 1'b0);
      tick('0, 1'b0, 1'b0, 1'b0);
      readout(-1, 0, 1'b0, 1'b0, '0);
      chk("t5_clear_wins", last_ch0, 0);

      // 5b: reset during SEND
      pulse(2);
      mon_if.out_ready = 1'b1;
      tick('0, 1'b0, 1'b1, 1'b0);
      tick('0, 1'b0, 1'b0, 1'b1);
      tick('0, 1'b0, 1'b0, 1'b0);
      chk("mid_send_valid", mon_if.out_valid, 1);
      rst = 1'b1;
      tick('0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_mid_valid", mon_if.out_valid, 0);
      chk("rst_mid_busy", busy, 0);
      readout(-1, 0, 1'b0, 1'b0, '0);

      // 6: rise in the SNAP cycle
      tick('0, 1'b1, 1'b0, 1'b0);
      pulse(0);
      pulse(0);
      readout(-1, 0, 1'b0, 1'b0, 4'b0001);
      chk("t6_first_ch0", last_ch0, 2);
      readout(-1, 0, 1'b0, 1'b0, '0);
      chk("t6_second_ch0", last_ch0, COR ? 1 : 3);

      // randomized activity and readouts
      for (int it = 0; it < 30; it++) begin
         int n;
         n = $urandom_range(5, 40);
         for (int k = 0; k < n; k++)
            tick(N'($urandom), ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
         readout($urandom_range(0, N - 1), $urandom_range(0, 4), 1'b1,
                 ($urandom_range(0, 7) == 0), N'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
